// File: rtl/cache_wbuf_ctrl.sv
// rtl/cache_wbuf_ctrl.sv - write-through store buffer and main-memory port controller
// Define WBUF_RAW_FWD_EN to forward buffered store data to a matching read miss.
module cache_wbuf_ctrl #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_valid,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  output logic                       wr_ready,
  input  logic                       rd_req,
  input  logic [ADDR_W-1:0]          rd_addr,
  output logic                       rd_done,
  output logic [DATA_W-1:0]          rd_data,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic [DATA_W-1:0]          mem_wdata,
  input  logic [DATA_W-1:0]          mem_rdata,
  input  logic                       mem_ready,
  output logic [$clog2(DEPTH+1)-1:0] buf_count,
  output logic                       buf_empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

`ifdef WBUF_RAW_FWD_EN
  typedef enum logic [1:0] {IDLE, DRAIN, READ, FWD} state_e;
`else
  typedef enum logic [1:0] {IDLE, DRAIN, READ} state_e;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     wptr_q, rptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              rd_done_q, rd_done_d;
  logic [DATA_W-1:0] rd_data_q, rd_data_d;
  logic              push, pop, rd_pending, hit;
  logic [PW-1:0]     idx;
`ifdef WBUF_RAW_FWD_EN
  logic [DATA_W-1:0] hit_data, fwd_q, fwd_d;
`endif

  assign wr_ready   = (count_q < CW'(DEPTH));
  assign push       = wr_valid & wr_ready;
  assign pop        = (state_q == DRAIN) & mem_ready;
  // rd_req is still high during the rd_done cycle; it must not restart a refill.
  assign rd_pending = rd_req & ~rd_done_q;

  // Oldest-to-youngest scan so the last hit is the youngest entry.
  always_comb begin
    hit = 1'b0;
    idx = '0;
`ifdef WBUF_RAW_FWD_EN
    hit_data = '0;
`endif
    for (int i = 0; i < DEPTH; i++) begin
      idx = rptr_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[idx] == rd_addr)) begin
        hit = 1'b1;
`ifdef WBUF_RAW_FWD_EN
        hit_data = data_q[idx];
`endif
      end
    end
    if (push && (wr_addr == rd_addr)) begin
      hit = 1'b1;
`ifdef WBUF_RAW_FWD_EN
      hit_data = wr_data;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    rd_done_d = 1'b0;
    rd_data_d = rd_data_q;
    count_d   = count_q;
`ifdef WBUF_RAW_FWD_EN
    fwd_d     = fwd_q;
`endif
    case (state_q)
      IDLE: begin
        if (rd_pending && !hit) begin
          state_d = READ;
        end else if (rd_pending) begin
`ifdef WBUF_RAW_FWD_EN
          state_d = FWD;
          fwd_d   = hit_data;
`else
          state_d = DRAIN;
`endif
        end else if (count_q != '0) begin
          state_d = DRAIN;
        end
      end
      DRAIN: if (mem_ready) state_d = IDLE;
      READ: begin
        if (mem_ready) begin
          state_d   = IDLE;
          rd_data_d = mem_rdata;
          rd_done_d = 1'b1;
        end
      end
`ifdef WBUF_RAW_FWD_EN
      FWD: begin
        state_d   = IDLE;
        rd_data_d = fwd_q;
        rd_done_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      rd_done_q <= 1'b0;
      rd_data_q <= '0;
`ifdef WBUF_RAW_FWD_EN
      fwd_q     <= '0;
`endif
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      rd_done_q <= rd_done_d;
      rd_data_q <= rd_data_d;
`ifdef WBUF_RAW_FWD_EN
      fwd_q     <= fwd_d;
`endif
      if (push) wptr_q <= wptr_q + PW'(1);
      if (pop)  rptr_q <= rptr_q + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[wptr_q] <= wr_addr;
      data_q[wptr_q] <= wr_data;
    end
  end

  // Memory port is a pure decode of the state register, so reset drops it at once.
  always_comb begin
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      DRAIN: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = addr_q[rptr_q];
        mem_wdata = data_q[rptr_q];
      end
      READ: begin
        mem_req  = 1'b1;
        mem_addr = rd_addr;
      end
      default: ;
    endcase
  end

  assign rd_done   = rd_done_q;
  assign rd_data   = rd_data_q;
  assign buf_count = count_q;
  assign buf_empty = (count_q == '0);

endmodule

// File: tb/tb_cache_wbuf_ctrl.sv
// tb/tb_cache_wbuf_ctrl.sv - self-checking bench for cache_wbuf_ctrl
module tb_cache_wbuf_ctrl;
  logic        clk = 1'b0, reset = 1'b1;
  logic        wr_valid = 1'b0, wr_ready, rd_req = 1'b0, rd_done;
  logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0, rd_data;
  logic        mem_req, mem_we, mem_ready = 1'b0;
  logic [31:0] mem_addr, mem_wdata, mem_rdata = '0;
  logic [2:0]  buf_count;
  logic        buf_empty;

  cache_wbuf_ctrl #(.DEPTH(4), .ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ready(wr_ready),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_done(rd_done), .rd_data(rd_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .buf_count(buf_count), .buf_empty(buf_empty)
  );

  always #5 clk = ~clk;

  int total = 0, bad = 0;
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model, program-order shadow, and transaction logs.
  logic [31:0] memm   [logic [31:0]];
  logic [31:0] shadow [logic [31:0]];
  logic        log_we[$];
  logic [31:0] log_addr[$], log_data[$], acc_addr[$], acc_data[$];
  int          resp_lat = 1000, req_age = 0, wr_n = 0, done_cnt = 0;
  logic        hs_pend = 1'b0, prev_done = 1'b0;
  logic [31:0] last_rd = '0;

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return memm.exists(a) ? memm[a] : (a ^ 32'hA5A5_0000);
  endfunction
  function automatic logic [31:0] sh_rd(input logic [31:0] a);
    return shadow.exists(a) ? shadow[a] : (a ^ 32'hA5A5_0000);
  endfunction
  function automatic logic [31:0] raddr();
    return 32'h300 + 32'($urandom_range(0, 7)) * 32'd4;
  endfunction

  always @(negedge clk) begin
    #1;
    if (mem_req) begin
      mem_ready = (resp_lat < 0) ? ($urandom_range(0, 2) == 0) : (req_age >= resp_lat);
      mem_rdata = mem_we ? $urandom : mem_rd(mem_addr);
    end else begin
      mem_ready = 1'b0;
      mem_rdata = $urandom;
    end
    #1;
    if (mem_req && mem_ready) begin
      log_we.push_back(mem_we);
      log_addr.push_back(mem_addr);
      log_data.push_back(mem_we ? mem_wdata : mem_rdata);
      if (mem_we) begin
        memm[mem_addr] = mem_wdata;
        wr_n++;
      end
      req_age = 0;
      hs_pend = 1'b1;
    end else if (mem_req) req_age++;
    else req_age = 0;
    if (wr_valid && wr_ready) begin
      acc_addr.push_back(wr_addr);
      acc_data.push_back(wr_data);
      shadow[wr_addr] = wr_data;
    end
  end

  always @(posedge clk) begin
    #1;
    if (rd_done) begin
      done_cnt++;
      last_rd = rd_data;
      chk("rd_done_single", prev_done, 1'b0);
    end
    prev_done = rd_done;
    if (hs_pend) chk("req_gap", mem_req, 1'b0);
    hs_pend = 1'b0;
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; wr_valid = 1'b0; rd_req = 1'b0; resp_lat = 1000;
    #3;
    log_we.delete(); log_addr.delete(); log_data.delete();
    acc_addr.delete(); acc_data.delete();
    wr_n = 0; done_cnt = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int k = 0;
    while (!(buf_empty && !mem_req) && k < 500) begin
      @(negedge clk);
      k++;
    end
    chk(name, {buf_empty, mem_req}, 2'b10);
  endtask

  task automatic wait_done(input string name);
    int k = 0;
    while (done_cnt == 0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk(name, done_cnt, 1);
    rd_req = 1'b0;
  endtask

  task automatic check_writes(input string name);
    logic [31:0] wa[$], wd[$];
    for (int i = 0; i < log_we.size(); i++)
      if (log_we[i]) begin
        wa.push_back(log_addr[i]);
        wd.push_back(log_data[i]);
      end
    chk({name, "_n"}, wa.size(), acc_addr.size());
    for (int i = 0; i < wa.size() && i < acc_addr.size(); i++) begin
      chk({name, "_addr"}, wa[i], acc_addr[i]);
      chk({name, "_data"}, wd[i], acc_data[i]);
    end
  endtask

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  cnt;
    logic        rdy;
  } vec_t;
  vec_t fill_tab[5];

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nreads;
    int rd_age;
    int done_seen;
    logic [31:0] exp_rd;

    fill_tab[0] = '{32'h100, 32'hD000_0000, 3'd1, 1'b1};
    fill_tab[1] = '{32'h104, 32'hD000_0001, 3'd2, 1'b1};
    fill_tab[2] = '{32'h108, 32'hD000_0002, 3'd3, 1'b1};
    fill_tab[3] = '{32'h10C, 32'hD000_0003, 3'd4, 1'b0};
    fill_tab[4] = '{32'h110, 32'hD000_0004, 3'd4, 1'b0};
    memm[32'h40] = 32'hCAFE;

    #1;
    chk("rst_mem", {mem_req, mem_we, mem_addr, mem_wdata}, '0);
    chk("rst_rd", {rd_done, rd_data}, '0);
    chk("rst_buf", {buf_count, buf_empty, wr_ready}, 5'b00011);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      chk("idle", {mem_req, wr_ready, buf_empty}, 3'b011);
    end

    // Fill with memory stalled: wr_ready drops after the 4th store.
    do_reset();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = fill_tab[i].addr; wr_data = fill_tab[i].data;
      @(posedge clk); #2;
      chk("fill_count", buf_count, fill_tab[i].cnt);
      chk("fill_ready", wr_ready, fill_tab[i].rdy);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    chk("fill_drain_req", {mem_req, mem_we}, 2'b11);
    chk("fill_drain_addr", mem_addr, fill_tab[0].addr);
    chk("fill_drain_data", mem_wdata, fill_tab[0].data);
    resp_lat = 0;
    wait_empty("fill_empty");
    check_writes("fill_order");

    // Drain order with ready two cycles after each request.
    do_reset();
    resp_lat = 2;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = fill_tab[i].addr ^ 32'h20; wr_data = ~fill_tab[i].data;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    wait_empty("order_empty");
    check_writes("drain_order");

    // Read miss beats pending drains.
    do_reset();
    resp_lat = 1;
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 32'h200; wr_data = 32'h1111;
    rd_req = 1'b1; rd_addr = 32'h40;
    @(negedge clk);
    wr_addr = 32'h204; wr_data = 32'h2222;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_done("prio_done");
    wait_empty("prio_empty");
    chk("prio_first_is_read", {log_we[0], log_addr[0]}, {1'b0, 32'h40});
    chk("prio_rd_data", last_rd, 32'hCAFE);
    chk("prio_done_count", done_cnt, 1);
    check_writes("prio_writes");

    // RAW hazard: store and read miss to the same address in one cycle.
    do_reset();
    resp_lat = 1;
    @(negedge clk);
    wr_valid = 1'b1; wr_addr = 32'h10; wr_data = 32'h1234;
    rd_req = 1'b1; rd_addr = 32'h10;
    @(negedge clk);
    wr_valid = 1'b0;
    wait_done("raw_done");
    wait_empty("raw_empty");
    chk("raw_rd_data", last_rd, 32'h1234);
    nreads = 0;
    foreach (log_we[i]) if (!log_we[i]) nreads++;
`ifdef WBUF_RAW_FWD_EN
    chk("raw_fwd_nreads", nreads, 0);
    chk("raw_fwd_nops", log_we.size(), 1);
`else
    chk("raw_nops", log_we.size(), 2);
    chk("raw_wr_first", {log_we[0], log_addr[0], log_data[0]}, {1'b1, 32'h10, 32'h1234});
    chk("raw_rd_second", {log_we[1], log_addr[1]}, {1'b0, 32'h10});
`endif

    // Async reset mid-drain with three entries.
    do_reset();
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      wr_valid = 1'b1; wr_addr = 32'h500 + 32'(4 * i); wr_data = 32'(i);
    end
    @(negedge clk);
    wr_valid = 1'b0;
    chk("arst_pre", {mem_req, mem_we, buf_count}, 5'b11011);
    #2 reset = 1'b1;
    #1;
    chk("arst_req", mem_req, 1'b0);
    chk("arst_count", buf_count, 3'd0);
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #2;
      chk("arst_post", {mem_req, buf_empty, wr_ready, buf_count}, 6'b011000);
    end

    // Randomized traffic against the program-order shadow.
    do_reset();
    resp_lat = -1;
    rd_age = 0;
    done_seen = 0;
    exp_rd = '0;
    for (int n = 0; n < 1500; n++) begin
      @(negedge clk);
      chk("rand_count", buf_count, acc_addr.size() - wr_n);
      if (rd_req) begin
        rd_age++;
        if (done_cnt != done_seen) begin
          chk("rand_rd_data", last_rd, exp_rd);
          done_seen = done_cnt;
          rd_req = 1'b0;
        end else if (rd_age > 300) begin
          chk("rand_rd_timeout", done_cnt - done_seen, 1);
          rd_req = 1'b0;
        end
      end else if ($urandom_range(0, 7) == 0) begin
        rd_addr = raddr();
        exp_rd = sh_rd(rd_addr);
        rd_req = 1'b1;
        rd_age = 0;
      end
      wr_valid = ($urandom_range(0, 1) == 1);
      wr_addr = raddr();
      while (rd_req && wr_addr == rd_addr) wr_addr = raddr();
      wr_data = $urandom;
    end
    @(negedge clk);
    wr_valid = 1'b0;
    for (int k = 0; k < 300 && rd_req; k++) begin
      if (done_cnt != done_seen) begin
        chk("rand_rd_data", last_rd, exp_rd);
        done_seen = done_cnt;
        rd_req = 1'b0;
      end else @(negedge clk);
    end
    chk("rand_rd_final", rd_req, 1'b0);
    rd_req = 1'b0;
    resp_lat = 0;
    wait_empty("rand_empty");
    check_writes("rand_wr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
